// File: rtl/fetch_pc.sv
// fetch_pc: instruction-fetch / PC stage with one outstanding imem request and a registered decode slot.
// Optional feature: define FETCH_MISALIGN_EN to halt on a misaligned redirect target instead of aligning it.
module fetch_pc #(
  parameter int unsigned       DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              nrst,
  output logic              imem_req,
  output logic [DWIDTH-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [DWIDTH-1:0] inst_pc,
  input  logic              dec_ready,
  input  logic              is_branch,
  input  logic              brnch,
  input  logic              jump,
  input  logic [DWIDTH-1:0] target,
  output logic              misalign_err
);

  localparam logic [31:0] NOP = 32'h00000013;

`ifdef FETCH_MISALIGN_EN
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;
`endif

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic              squash_q, squash_d;
  logic              instValid_q, instValid_d;
  logic [31:0]       inst_q, inst_d;
  logic [DWIDTH-1:0] instPc_q, instPc_d;

  logic              redirect;
  logic              accept;
  logic [DWIDTH-1:0] tgtAligned;

  assign redirect   = (is_branch & brnch) | jump;
  assign accept     = imem_req & imem_ready;
  assign tgtAligned = target & {{(DWIDTH-2){1'b1}}, 2'b00};

  // Request depends only on registered state and decode back-pressure, never on redirect.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    if (!nrst || state_q == IDLE) begin
      imem_addr = RESET_PC;
    end else if (state_q == FETCH) begin
      imem_req = !instValid_q | dec_ready;
    end
  end

`ifdef FETCH_MISALIGN_EN
  logic misalign_q, misalign_d;
  logic misaligned;
  assign misaligned = |target[1:0];
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    squash_d    = squash_q;
    instValid_d = instValid_q;
    inst_d      = inst_q;
    instPc_d    = instPc_q;
`ifdef FETCH_MISALIGN_EN
    misalign_d  = 1'b0;
`endif

    if (instValid_q && dec_ready) begin
      instValid_d = 1'b0;
    end

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (accept) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = FETCH;
          if (squash_q) begin
            squash_d = 1'b0;
          end else begin
            inst_d      = imem_rdata;
            instPc_d    = pc_q;
            instValid_d = 1'b1;
            pc_d        = pc_q + DWIDTH'(4);
          end
        end
      end
`ifdef FETCH_MISALIGN_EN
      HALT: state_d = HALT;
`endif
      default: state_d = IDLE;
    endcase

    // Redirect overrides any capture; an in-flight request stays marked for discard.
    if (redirect && (state_q == FETCH || state_q == WAIT)) begin
      instValid_d = 1'b0;
      inst_d      = inst_q;
      instPc_d    = instPc_q;
      squash_d    = (state_d == WAIT);
`ifdef FETCH_MISALIGN_EN
      if (misaligned) begin
        pc_d       = pc_q;
        misalign_d = 1'b1;
        state_d    = HALT;
      end else begin
        pc_d = tgtAligned;
      end
`else
      pc_d = tgtAligned;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      squash_q    <= 1'b0;
      instValid_q <= 1'b0;
      inst_q      <= NOP;
      instPc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      squash_q    <= squash_d;
      instValid_q <= instValid_d;
      inst_q      <= inst_d;
      instPc_q    <= instPc_d;
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign inst_valid = instValid_q;
  assign inst       = inst_q;
  assign inst_pc    = instPc_q;

endmodule
